// File: rtl/mult_pkg.sv
// Shared sizing for the approximate multiplier datapath: default widths,
// shift-counter width and the fixed alignment of the truncated product.
package mult_pkg;

    localparam int N_DEF = 16;
    localparam int K_DEF = 8;

    function automatic int cw_of(input int n);
        return $clog2(n);
    endfunction

    // The K x K product lands in the top 2K bits of the 2N-bit result.
    function automatic int align_of(input int n, input int k);
        return 2 * n - 2 * k;
    endfunction

endpackage

// File: rtl/lead_shift_reg.sv
// Loadable left shift register that normalises its operand to a leading one,
// counting the shifts taken. A zero operand is never shifted.
module lead_shift_reg #(
    parameter int N  = 16,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld,
    input  logic [N-1:0]  d_in,
    input  logic          shift_en,
    input  logic          count_en,
    output logic [N-1:0]  value,
    output logic [CW-1:0] count,
    output logic          shifting
);

    logic [N-1:0]  value_q, value_d;
    logic [CW-1:0] count_q, count_d;

    assign shifting = ~value_q[N-1] & (value_q != '0);
    assign value    = value_q;
    assign count    = count_q;

    always_comb begin
        value_d = value_q;
        count_d = count_q;
        if (ld) begin
            value_d = d_in;
            count_d = '0;
        end else begin
            if (shift_en && shifting) begin
                value_d = value_q << 1;
            end
            if (count_en && shifting) begin
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
            count_q <= '0;
        end else begin
            value_q <= value_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/approx_mult_datapath.sv
// Datapath for the approximate multiplier: normalise both operands, multiply
// their top K bits, then shift the product back right by the total normalisation.
module approx_mult_datapath
    import mult_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int K  = K_DEF,
    parameter int CW = cw_of(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   a_in,
    input  logic [N-1:0]   b_in,
    input  logic           ld,
    input  logic           ld_l_shift,
    input  logic           l_count_enable,
    input  logic           ld_r_shift,
    input  logic           r_count_enable,
    output logic           a_shifting,
    output logic           b_shifting,
    output logic           r_shifting,
    output logic [2*N-1:0] result
);

    localparam int ALIGN = align_of(N, K);

    logic [N-1:0]   a_val, b_val;
    logic [CW-1:0]  la, lb;
    logic [CW:0]    l_sum;
    logic [2*K-1:0] prod;
    logic [2*N-1:0] prod_aligned;

    logic [2*N-1:0] r_q, r_d;
    logic [CW:0]    rc_q, rc_d;

    lead_shift_reg #(.N(N), .CW(CW)) u_a_reg (
        .clk      (clk),
        .rst      (rst),
        .ld       (ld),
        .d_in     (a_in),
        .shift_en (ld_l_shift),
        .count_en (l_count_enable),
        .value    (a_val),
        .count    (la),
        .shifting (a_shifting)
    );

    lead_shift_reg #(.N(N), .CW(CW)) u_b_reg (
        .clk      (clk),
        .rst      (rst),
        .ld       (ld),
        .d_in     (b_in),
        .shift_en (ld_l_shift),
        .count_en (l_count_enable),
        .value    (b_val),
        .count    (lb),
        .shifting (b_shifting)
    );

    // Widen before adding so la+lb (up to 2N-2) cannot wrap.
    assign l_sum        = {1'b0, la} + {1'b0, lb};
    assign prod         = a_val[N-1:N-K] * b_val[N-1:N-K];
    assign prod_aligned = (2*N)'(prod) << ALIGN;
    assign r_shifting   = (rc_q != l_sum);
    assign result       = r_q;

    always_comb begin
        r_d  = r_q;
        rc_d = rc_q;
        if (ld_r_shift) begin
            r_d  = prod_aligned;
            rc_d = '0;
        end else if (ld) begin
            rc_d = '0;
        end else if (r_count_enable && r_shifting) begin
            r_d  = r_q >> 1;
            rc_d = rc_q + (CW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q  <= '0;
            rc_q <= '0;
        end else begin
            r_q  <= r_d;
            rc_q <= rc_d;
        end
    end

endmodule

// File: tb/tb_approx_mult_datapath.sv
// Scoreboard bench for approx_mult_datapath: directed operand pairs with
// hand-computed flags and results, checked by a monitor on the falling edge.
module tb_approx_mult_datapath;

    localparam logic [4:0] S_LD  = 5'b10000;
    localparam logic [4:0] S_LS  = 5'b01000;
    localparam logic [4:0] S_LC  = 5'b00100;
    localparam logic [4:0] S_RS  = 5'b00010;
    localparam logic [4:0] S_RCE = 5'b00001;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a_in, b_in;
    logic        ld, ld_l_shift, l_count_enable, ld_r_shift, r_count_enable;
    logic        a_shifting, b_shifting, r_shifting;
    logic [31:0] result;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        a_sh;
        logic        b_sh;
        logic        r_sh;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   total = 0;
    int   bad   = 0;

    approx_mult_datapath dut (
        .clk            (clk),
        .rst            (rst),
        .a_in           (a_in),
        .b_in           (b_in),
        .ld             (ld),
        .ld_l_shift     (ld_l_shift),
        .l_count_enable (l_count_enable),
        .ld_r_shift     (ld_r_shift),
        .r_count_enable (r_count_enable),
        .a_shifting     (a_shifting),
        .b_shifting     (b_shifting),
        .r_shifting     (r_shifting),
        .result         (result)
    );

    always #5 clk = ~clk;

    // Monitor: the registered state is stable at the falling edge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            cur = sb.pop_front();
            total++;
            if (result !== cur.res || a_shifting !== cur.a_sh ||
                b_shifting !== cur.b_sh || r_shifting !== cur.r_sh) begin
                bad++;
                $display("[TB] FAIL %s: got result=%h a/b/r=%b%b%b, want result=%h a/b/r=%b%b%b",
                         cur.name, result, a_shifting, b_shifting, r_shifting,
                         cur.res, cur.a_sh, cur.b_sh, cur.r_sh);
            end
        end
    end

    task automatic applyStimulus(input logic [4:0] strobes, input int cycles);
        {ld, ld_l_shift, l_count_enable, ld_r_shift, r_count_enable} = strobes;
        repeat (cycles) @(posedge clk);
        #1;
        {ld, ld_l_shift, l_count_enable, ld_r_shift, r_count_enable} = 5'b0;
    endtask

    task automatic applyReset(input logic [4:0] strobes);
        rst = 1'b1;
        {ld, ld_l_shift, l_count_enable, ld_r_shift, r_count_enable} = strobes;
        @(posedge clk);
        #1;
        rst = 1'b0;
        {ld, ld_l_shift, l_count_enable, ld_r_shift, r_count_enable} = 5'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] res,
                               input logic a_sh, input logic b_sh, input logic r_sh);
        exp_t e;
        e.name = name;
        e.res  = res;
        e.a_sh = a_sh;
        e.b_sh = b_sh;
        e.r_sh = r_sh;
        sb.push_back(e);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        a_in = '0;
        b_in = '0;
        {ld, ld_l_shift, l_count_enable, ld_r_shift, r_count_enable} = 5'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset", 32'h0, 1'b0, 1'b0, 1'b0);

        a_in = 16'h8000; b_in = 16'h8000;
        applyStimulus(S_LD, 1);
        checkOutput("c1_load", 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(S_RS, 1);
        checkOutput("c1_prod", 32'h4000_0000, 1'b0, 1'b0, 1'b0);

        a_in = 16'h0001; b_in = 16'h0001;
        applyStimulus(S_LD, 1);
        checkOutput("c2_load", 32'h4000_0000, 1'b1, 1'b1, 1'b0);
        applyStimulus(S_LS | S_LC, 15);
        checkOutput("c2_norm", 32'h4000_0000, 1'b0, 1'b0, 1'b1);
        applyStimulus(S_RS, 1);
        checkOutput("c2_prod", 32'h4000_0000, 1'b0, 1'b0, 1'b1);
        applyStimulus(S_RCE, 30);
        checkOutput("c2_shift30", 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        applyStimulus(S_RCE, 1);
        checkOutput("c2_extra", 32'h0000_0001, 1'b0, 1'b0, 1'b0);

        a_in = 16'h00FF; b_in = 16'h0003;
        applyStimulus(S_LD, 1);
        applyStimulus(S_LS | S_LC, 7);
        checkOutput("c3_s7", 32'h0000_0001, 1'b1, 1'b1, 1'b1);
        applyStimulus(S_LS | S_LC, 1);
        checkOutput("c3_s8", 32'h0000_0001, 1'b0, 1'b1, 1'b1);
        applyStimulus(S_LS | S_LC, 6);
        checkOutput("c3_s14", 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        applyStimulus(S_RS, 1);
        checkOutput("c3_prod", 32'hBF40_0000, 1'b0, 1'b0, 1'b1);
        applyStimulus(S_RCE, 21);
        checkOutput("c3_r21", 32'h0000_05FA, 1'b0, 1'b0, 1'b1);
        applyStimulus(S_RCE, 1);
        checkOutput("c3_r22", 32'h0000_02FD, 1'b0, 1'b0, 1'b0);

        a_in = 16'h1234; b_in = 16'h5678;
        applyStimulus(S_LD, 1);
        applyStimulus(S_LS | S_LC, 3);
        checkOutput("c4_norm", 32'h0000_02FD, 1'b0, 1'b0, 1'b1);
        applyStimulus(S_RS, 1);
        checkOutput("c4_prod", 32'h616C_0000, 1'b0, 1'b0, 1'b1);
        applyStimulus(S_RCE, 4);
        checkOutput("c4_res", 32'h0616_C000, 1'b0, 1'b0, 1'b0);

        a_in = 16'h0001; b_in = 16'h0001;
        applyStimulus(S_LD, 1);
        applyStimulus(S_LS | S_LC, 5);
        checkOutput("rst_pre", 32'h0616_C000, 1'b1, 1'b1, 1'b1);
        applyReset(S_LS | S_LC | S_RCE);
        checkOutput("rst_mid", 32'h0, 1'b0, 1'b0, 1'b0);

        a_in = 16'h0000; b_in = 16'h8000;
        applyStimulus(S_LD, 1);
        checkOutput("c5_load", 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(S_LS | S_LC, 3);
        applyStimulus(S_RS, 1);
        checkOutput("c5_prod", 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(S_RCE, 2);
        checkOutput("c5_res", 32'h0, 1'b0, 1'b0, 1'b0);

        a_in = 16'h0001; b_in = 16'h0001;
        applyStimulus(S_LD, 1);
        a_in = 16'h4000; b_in = 16'h4000;
        applyStimulus(S_LD | S_LS | S_LC, 1);
        checkOutput("pri_ld", 32'h0, 1'b1, 1'b1, 1'b0);
        applyStimulus(S_RS, 1);
        checkOutput("pri_ld_prod", 32'h1000_0000, 1'b1, 1'b1, 1'b0);
        applyStimulus(S_LS | S_LC, 1);
        checkOutput("pri_norm", 32'h1000_0000, 1'b0, 1'b0, 1'b1);
        applyStimulus(S_RS | S_RCE, 1);
        checkOutput("pri_rs", 32'h4000_0000, 1'b0, 1'b0, 1'b1);
        applyStimulus(S_RCE, 2);
        checkOutput("pri_res", 32'h1000_0000, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        if (sb.size() > 0) begin
            $display("[TB] FAIL drain: pending=%0d want 0", sb.size());
            total += sb.size();
            bad   += sb.size();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/approx_mult_datapath.md
Name: approx_mult_datapath

Overview:
- Datapath end of the approximate-multiplier control interface.
- Responds to the sequencing controller's load/shift/count strobes and returns the `a_shifting`, `b_shifting` and `r_shifting` status flags the controller waits on.
- Operation:
  - Normalises each N-bit operand left until its MSB is 1.
  - Multiplies the top K bits of each operand.
  - Shifts the 2N-bit product right by the total left-shift count.
- The result is the approximate N×N product.

Parameters:
- N, 16, operand width.
- K, 8, truncated multiplier width (K <= N).
- CW, $clog2(N), per-operand shift counter width.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset (driven by the controller's rst).
- a_in, input, N, operand A.
- b_in, input, N, operand B.
- ld, input, 1, load a_in/b_in; clear all counters.
- ld_l_shift, input, 1, left-shift A/B registers whose flag is high.
- l_count_enable, input, 1, increment left counters whose flag is high.
- ld_r_shift, input, 1, load truncated product into R; clear r counter.
- r_count_enable, input, 1, right-shift R by 1 and increment r counter when r_shifting.
- a_shifting, output, 1, A not yet normalised.
- b_shifting, output, 1, B not yet normalised.
- r_shifting, output, 1, R not yet de-normalised.
- result, output, 2N, R register contents.

Behaviour:
- Registers:
  - A[N-1:0], B[N-1:0], R[2N-1:0].
  - la[CW-1:0], lb[CW-1:0], rc[CW:0].
- All registers update on posedge clk.
- Reset: rst=1 clears A, B, R, la, lb, rc to 0, so a_shifting=b_shifting=r_shifting=0 and result=0. rst overrides every other input, including mid-operation.
- Flags, combinational from registers (0-cycle latency):
  - a_shifting = ~A[N-1] & (A != 0); b_shifting likewise on B.
  - r_shifting = (rc != la + lb), compared at CW+1 bits.
- ld=1:
  - A<=a_in, B<=b_in, la<=0, lb<=0, rc<=0.
  - ld has priority over ld_l_shift and l_count_enable in the same cycle.
- Left phase:
  - ld_l_shift & a_shifting: A <= A<<1.
  - l_count_enable & a_shifting: la <= la+1.
  - B/lb identical and independent, so A and B may finish on different cycles.
  - When a flag is low, strobes have no effect on that operand.
  - The zero guard stops shifting a zero operand, so la, lb never exceed N-1 and never wrap.
- Product load, ld_r_shift=1:
  - R <= (A[N-1:N-K] * B[N-1:N-K]) << (2N-2K).
  - rc <= 0.
  - The multiply is combinational, unsigned, full 2K-bit width.
- ld_r_shift has priority over r_count_enable in the same cycle.
- Right phase: r_count_enable & r_shifting: R <= R>>1, rc <= rc+1.
  - rc stops at la+lb (max 2N-2); further strobes are ignored.
- Final value: result = R = P<<(2N-2K-la-lb), the exact product when both operands have at most K significant bits after normalisation.
- Strobes while ld_r_shift has not yet occurred: r_shifting compares the stale rc; the controller must issue ld_r_shift before r_count_enable.
- Operands must not change during the operation: a_in/b_in are sampled only on ld.

Decomposition:
- Package mult_pkg: N, K defaults; CW derivation; product-alignment constant 2N-2K.
- Sub-module lead_shift_reg (N, CW):
  - Loadable left shift register + leading-one counter + shifting flag.
  - Instantiated twice, for A and B.
- R register, rc counter and multiplier stay in the top.

Test Plan:
- a_in=16'h8000, b_in=16'h8000: ld; a_shifting=b_shifting=0 immediately; ld_r_shift → R=32'h4000_0000, r_shifting=0; result=32'h4000_0000.
- a_in=16'h0001, b_in=16'h0001: 15 shift/count strobes each → la=lb=15; ld_r_shift then 30 r_count_enable → result=32'h0000_0001; a 31st strobe leaves the result unchanged.
- a_in=16'h00FF, b_in=16'h0003:
  - a_shifting drops after 8 strobes; b_shifting drops after 14.
  - R=32'hBF40_0000; after 22 right shifts, result=32'h0000_02FD (exact 765).
- a_in=16'h1234, b_in=16'h5678:
  - la=3, lb=1, top bytes 8'h91, 8'hAC.
  - result=32'h0616_C000 after 4 right shifts (approximate).
- a_in=0, b_in=16'h8000: a_shifting=0 at once, strobes do not move A; after ld_r_shift, R=0 and r_shifting=0; result=0.
- Reset and priority:
  - rst=1 mid left phase (a_in=1, after 5 shifts) clears all registers and flags in one cycle.
  - ld with ld_l_shift reloads without shifting.
  - ld_r_shift with r_count_enable loads without shifting.
